hilo_seq: RTL and testbench

- Iterative multiply/divide sequencer that owns the HI/LO register pair.
- Replaces the single-cycle combinational multiplier.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a one-bit-per-cycle shift-add or restoring-divide loop.
- Drives a stall to the hazard unit while any HI/LO access hits a busy unit.
- Also services MTHI/MTLO writes.

---
 rtl/hilo_seq.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_hilo_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_seq.sv
// hilo_seq -- iterative multiply/divide sequencer that owns the HI/LO pair.
//
// It accepts MULT/MULTU/DIV/DIVU from the execute stage. The operation runs one
// bit per cycle, using shift-add for multiply and restoring division for divide.
// MTHI/MTLO writes are also serviced here. The block raises a combinational
// stall while it is busy and the execute stage touches HI/LO.
//
// Optional feature macro: HILO_SEQ_DIV_EN
//   defined   : divide support is built.
//   undefined : divider logic is omitted. DIV/DIVU starts are accepted as no-ops.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   start    in   issue operation (op, a, b valid)
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     in   rs / rt operands
//   hi_we    in   MTHI write request
//   lo_we    in   MTLO write request
//   wd       in   MTHI/MTLO data
//   hilo_rd  in   MFHI/MFLO in execute stage
//   clr      in   synchronous abort (pipeline flush)
//   hi, lo   out  HI / LO registers
//   busy     out  sequencer not idle
//   done     out  one-cycle pulse when an operation updates HI/LO
//   stall    out  busy & (start | hilo_rd | hi_we | lo_we)
//   dz       out  sticky divide-by-zero flag, cleared by next accepted start
module hilo_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  input  logic             hilo_rd,
  input  logic             clr,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             dz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  // Two's-complement negation at operand width.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation at double (product) width.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude for signed ops; the raw value is used for unsigned ops.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
    if (is_signed && x[WIDTH-1]) begin
      return neg_w(x);
    end else begin
      return x;
    end
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // acc: multiply -> {product_hi, product_lo/multiplier}; divide -> {rem, quo}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // opb: multiplicand (multiply) or divisor (divide)
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;   // negate product / quotient
  logic               neg_hi_q, neg_hi_d;   // negate remainder
  logic               dzp_q, dzp_d;         // pending divide-by-zero result
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_fix_s;
`ifdef HILO_SEQ_DIV_EN
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     rem_sub_s;
`endif

  // Datapath helpers for the current state.
  always_comb begin
    a_mag_s   = mag(a, ~op[0]);
    b_mag_s   = mag(b, ~op[0]);
    // The carry out of the upper-half add is kept as it shifts into the product.
    mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    if (neg_lo_q) begin
      mul_fix_s = neg_2w(acc_q);
    end else begin
      mul_fix_s = acc_q;
    end
`ifdef HILO_SEQ_DIV_EN
    // The shifted remainder needs one extra bit before the trial subtract.
    // A set MSB in rem_sub_s means a borrow, so the remainder stays unchanged.
    rem_sh_s  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub_s = rem_sh_s - {1'b0, opb_q};
`endif
  end

  // Next-state and next-value logic for the sequencer and HI/LO.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dzp_d    = dzp_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;

    if (clr) begin
      // Flush. Drop any in-flight or same-cycle operation or write.
      // HI/LO keep their values.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hi_we) begin
            hi_d = wd;
          end else begin
            hi_d = hi_q;
          end
          if (lo_we) begin
            lo_d = wd;
          end else begin
            lo_d = lo_q;
          end
          if (start) begin
            if (!op[1]) begin
              // The multiplier sits in the low half and shifts out as the product shifts in.
              state_d  = S_CALC;
              cnt_d    = CNT_INIT;
              acc_d    = {{WIDTH{1'b0}}, b_mag_s};
              opb_d    = a_mag_s;
              is_div_d = 1'b0;
              neg_lo_d = ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi_d = 1'b0;
              dzp_d    = 1'b0;
              dz_d     = 1'b0;
            end else begin
`ifdef HILO_SEQ_DIV_EN
              is_div_d = 1'b1;
              dz_d     = 1'b0;
              cnt_d    = CNT_INIT;
              if (b == {WIDTH{1'b0}}) begin
                // The result is preloaded so that FIX writes hi = raw dividend, lo = all ones.
                state_d  = S_FIX;
                acc_d    = {a, {WIDTH{1'b1}}};
                opb_d    = b;
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
                dzp_d    = 1'b1;
              end else begin
                state_d  = S_CALC;
                acc_d    = {{WIDTH{1'b0}}, a_mag_s};
                opb_d    = b_mag_s;
                neg_lo_d = ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi_d = ~op[0] & a[WIDTH-1];
                dzp_d    = 1'b0;
              end
`else
              // With no divider built, a divide issue is accepted and ignored.
              state_d = S_IDLE;
`endif
            end
          end else begin
            state_d = S_IDLE;
          end
        end

        S_CALC: begin
          cnt_d = cnt_q - CNT_ONE;
`ifdef HILO_SEQ_DIV_EN
          if (is_div_q) begin
            if (!rem_sub_s[WIDTH]) begin
              acc_d = {rem_sub_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
          end else begin
            if (acc_q[0]) begin
              acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
            end else begin
              acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
          end
`else
          if (acc_q[0]) begin
            acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
          end
`endif
          // The last iteration is the one where the counter drops from 1 to 0.
          if (cnt_q == CNT_ONE) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end

        S_FIX: begin
          if (is_div_q) begin
            if (neg_lo_q) begin
              lo_d = neg_w(acc_q[WIDTH-1:0]);
            end else begin
              lo_d = acc_q[WIDTH-1:0];
            end
            if (neg_hi_q) begin
              hi_d = neg_w(acc_q[2*WIDTH-1:WIDTH]);
            end else begin
              hi_d = acc_q[2*WIDTH-1:WIDTH];
            end
            if (dzp_q) begin
              dz_d = 1'b1;
            end else begin
              dz_d = dz_q;
            end
          end else begin
            hi_d = mul_fix_s[2*WIDTH-1:WIDTH];
            lo_d = mul_fix_s[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dzp_q    <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dzp_q    <= dzp_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign dz    = dz_q;
  // This is combinational so that the issuing instruction is held in the same cycle.
  assign stall = busy_q & (start | hilo_rd | hi_we | lo_we);

endmodule

// File: tb/tb_hilo_seq.sv
// tb_hilo_seq -- self-checking bench for hilo_seq.
// An arithmetic reference model (HI/LO, completion countdown) is compared to the
// DUT on every falling edge. Directed sequences pin literal results.
module tb_hilo_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, hi_we, lo_we, hilo_rd, clr;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall, dz;

  hilo_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .hilo_rd(hilo_rd), .clr(clr),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall), .dz(dz)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] mul_ref(input logic uns, input logic [31:0] x, input logic [31:0] y);
    longint p;
    if (uns) p = longint'({32'd0, x}) * longint'({32'd0, y});
    else     p = longint'(signed'(x)) * longint'(signed'(y));
    return p;
  endfunction

`ifdef HILO_SEQ_DIV_EN
  // Returns {remainder, quotient}.
  function automatic logic [63:0] div_ref(input logic uns, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q, r;
    longint sq, sr;
    if (uns) begin
      q = x / y;
      r = x % y;
    end else begin
      sq = longint'(signed'(x)) / longint'(signed'(y));
      sr = longint'(signed'(x)) % longint'(signed'(y));
      q = sq[31:0];
      r = sr[31:0];
    end
    return {r, q};
  endfunction
`endif

  logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic         m_dz = 1'b0, m_done = 1'b0, r_dz = 1'b0;
  int           m_left = 0;   // cycles until the pending result lands; 0 = idle

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hi <= '0; m_lo <= '0; m_dz <= 1'b0; m_done <= 1'b0; m_left <= 0;
      r_hi <= '0; r_lo <= '0; r_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (clr) begin
        m_left <= 0;
      end else if (m_left == 0) begin
        if (hi_we) m_hi <= wd;
        if (lo_we) m_lo <= wd;
        if (start) begin
          if (!op[1]) begin
            {r_hi, r_lo} <= mul_ref(op[0], a, b);
            r_dz <= 1'b0; m_dz <= 1'b0; m_left <= W + 1;
          end else begin
`ifdef HILO_SEQ_DIV_EN
            m_dz <= 1'b0;
            if (b == 32'd0) begin
              r_hi <= a; r_lo <= 32'hFFFF_FFFF; r_dz <= 1'b1; m_left <= 1;
            end else begin
              {r_hi, r_lo} <= div_ref(op[0], a, b);
              r_dz <= 1'b0; m_left <= W + 1;
            end
`endif
          end
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= r_hi; m_lo <= r_lo; m_done <= 1'b1;
          if (r_dz) m_dz <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cmp_hi", 64'(hi), 64'(m_hi));
    chk("cmp_lo", 64'(lo), 64'(m_lo));
    chk("cmp_busy", 64'(busy), 64'(m_left != 0));
    chk("cmp_done", 64'(done), 64'(m_done));
    chk("cmp_dz", 64'(dz), 64'(m_dz));
    chk("cmp_stall", 64'(stall), 64'((m_left != 0) && (start || hilo_rd || hi_we || lo_we)));
  end

  // ---------------- directed helpers ----------------
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat = index of the edge (start edge = 0) after which done was seen, -1 on timeout.
  task automatic wait_done(output int lat, output int bcnt);
    lat = -1;
    bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  int lat, bcnt;
  logic [W-1:0] h0, l0;

  initial begin
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_rd = 1'b0; clr = 1'b0;
    op = 2'b00; a = '0; b = '0; wd = '0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_dz", 64'(dz), 64'd0);
    rst = 1'b1;

    // MULTU max*max
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_busy_cycles", 64'(bcnt), 64'd33);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);

    // MULT -3*5
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done(lat, bcnt);
    chk("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_neg_lo", 64'(lo), 64'hFFFF_FFF1);

`ifdef HILO_SEQ_DIV_EN
    issue(2'b11, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    chk("divu_lat", 64'(lat), 64'd33);
    chk("divu_lo", 64'(lo), 64'h0000_000E);
    chk("divu_hi", 64'(hi), 64'h0000_0002);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bcnt);
    chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    issue(2'b10, 32'd5, 32'd0);
    wait_done(lat, bcnt);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("dz_hi", 64'(hi), 64'd5);
    chk("dz_flag", 64'(dz), 64'd1);
    issue(2'b01, 32'd3, 32'd4);
    chk("dz_cleared_by_start", 64'(dz), 64'd0);
    wait_done(lat, bcnt);
    chk("multu_3x4_lo", 64'(lo), 64'd12);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'd0);
    chk("div_ovf_dz", 64'(dz), 64'd0);
`else
    h0 = hi; l0 = lo;
    issue(2'b11, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nodiv_busy", 64'(busy), 64'd0);
      chk("nodiv_done", 64'(done), 64'd0);
    end
    chk("nodiv_hi", 64'(hi), 64'(h0));
    chk("nodiv_lo", 64'(lo), 64'(l0));
    chk("nodiv_dz", 64'(dz), 64'd0);
`endif

    // MTLO, then MULT 2*3 with MFLO hammering while busy
    @(posedge clk); #1;
    lo_we = 1'b1; wd = 32'h0000_1234;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h1234);
    issue(2'b00, 32'd2, 32'd3);
    hilo_rd = 1'b1;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      chk("rd_stall", 64'(stall), 64'd1);
      chk("rd_lo_held", 64'(lo), 64'h1234);
    end
    chk("rd_lat", 64'(lat), 64'd33);
    chk("rd_lo", 64'(lo), 64'd6);
    chk("rd_hi", 64'(hi), 64'd0);
    chk("rd_stall_after", 64'(stall), 64'd0);
    hilo_rd = 1'b0;

    // clr abort mid-multiply
    h0 = hi; l0 = lo;
    issue(2'b01, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("clr_no_done", 64'(done), 64'd0);
    end
    chk("clr_hi", 64'(hi), 64'(h0));
    chk("clr_lo", 64'(lo), 64'(l0));

    // reset mid-multiply, with nonzero HI first
    @(posedge clk); #1;
    hi_we = 1'b1; wd = 32'h0000_ABCD;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hABCD);
    issue(2'b01, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_dz", 64'(dz), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Randomized traffic, checked by the every-cycle comparator
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 99) < 12);
      op      = 2'($urandom_range(0, 3));
      a       = pick();
      b       = pick();
      hilo_rd = ($urandom_range(0, 3) == 0);
      clr     = ($urandom_range(0, 49) == 0);
      wd      = 32'($urandom);
      if (clr) begin
        hi_we = 1'b0;
        lo_we = 1'b0;
      end else begin
        hi_we = ($urandom_range(0, 19) == 0);
        lo_we = ($urandom_range(0, 19) == 0);
      end
    end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_rd = 1'b0; clr = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
